uop_sequencer: RTL and testbench
================================

// Module: uop_sequencer
// PURPOSE
//  Instruction front buffer plus micro-op sequencer in front of the scheduler. Queues fetched 16-bit
//  instructions and expands each into 1..MAX_UOPS micro-ops issued one at a time (PUSH_PC before call
//  bodies; optional push/pop-multiple). Replaces the single pre-stage flop with a counted multi-stage
//  sequence, and drives the decoder's per-stage signals.
// PARAMETERS
//  LOG2_NR     4  register index width
//  NSHIFT      2  bits per serial cycle; width of uop_pc_words
//  MAX_UOPS    5  max micro-ops per instruction (1 body + 4 pushes/pops)
//  IBUF_DEPTH  2  instruction FIFO depth, power of 2, >=1
// PORTS
//  clk           in   1        clock
//  reset         in   1        synchronous, active-high
//  inst_valid    in   1        fetched instruction offered
//  inst          in   16       instruction word
//  inst_ready    out  1        FIFO can accept (low while flush is high)
//  flush         in   1        PC redirected: drop FIFO and current instruction
//  uop_valid     out  1        micro-op presented to scheduler
//  uop_inst      out  16       instruction being executed
//  uop_kind      out  2        UOP_NORMAL / UOP_PUSH_PC / UOP_PUSH_REG / UOP_POP_REG
//  uop_reg       out  LOG2_NR  register for PUSH_REG/POP_REG, else 0
//  uop_pc_words  out  NSHIFT   words added to PC for PUSH_PC: 2 if long form (arg2[5:2]==0, arg2[0]==1, not branch) else 1
//  uop_index     out  $clog2(MAX_UOPS)  micro-op number within instruction, 0-based
//  uop_last      out  1        current micro-op is the final one
//  uop_done      in   1        scheduler finished current micro-op (sc_inst_done)
//  inst_done     out  1        = uop_valid & uop_done & uop_last (combinational)
//  busy          out  1        uop_valid | FIFO non-empty
// BEHAVIOUR
//  - Reset: FIFO empty, exec idle; uop_valid=0, uop_inst=0, uop_kind=UOP_NORMAL, uop_reg=0, uop_index=0,
//    uop_last=0, uop_pc_words=0, inst_done=0, busy=0, inst_ready=1 the cycle after reset falls.
//  - Accept on inst_valid & inst_ready. Exec reg loads from FIFO head when idle, or on inst_done
//    (zero bubble). Accepted into empty, idle sequencer at T -> uop_valid at T+1.
//  - FIFO full and exec not finishing -> inst_ready=0. Full + inst_done + inst_valid same cycle:
//    head pops into exec and new word is accepted (ready = !full | inst_done).
//  - Exec states IDLE, RUN. On load, compute uop list: call (0000/CC_CALL/bbbbbbbb) or call src
//    (0010000001iiiiii) -> [PUSH_PC, NORMAL]; everything else -> [NORMAL].
//  - uop_done with uop_valid=0 ignored. uop_done on non-last uop -> uop_index+1 next cycle, same inst.
//  - Outputs stable while uop_valid & !uop_done.
//  - flush: next cycle FIFO empty, exec IDLE, uop_valid=0; inst_valid that cycle dropped. flush with
//    inst_done same cycle: inst_done still asserted (retires), successor discarded.
//  - Reset mid-sequence: abandons instruction, no inst_done.
// CONFIGURATION
//  UOP_SEQUENCER_PUSHM_EN defined: pattern 16'b0001_0000_11_d0_mmmm is push/pop multiple; d=0 push,
//  d=1 pop; mask bit k selects r16 register 2k. Push order high->low reg, pop low->high, one
//  PUSH_REG/POP_REG uop each, no NORMAL uop. Mask 0: zero uops; inst_done is not driven, the
//  instruction retires silently one cycle after load (uop_valid stays 0).
//  Undefined: pattern decodes as ordinary single NORMAL uop; uop_kind never PUSH_REG/POP_REG.
// STRUCTURE
//  Shared package (seq_pkg): UOP_* kind codes, CC_CALL, CALL_SRC/PUSHM match patterns and masks,
//  popcount/priority helpers. One sub-module: inst_fifo (sync FIFO, IBUF_DEPTH, full/empty, push/pop
//  same cycle legal when full). Uop list held as remaining-mask + index counter, not an unrolled array.
// TESTING
//  1. 0x8123 at T, uop_done at T+3 -> uop_valid T+1..T+3, kind NORMAL, uop_last=1, inst_done at T+3.
//  2. Call 0x0Fxx (cccc=CC_CALL) -> uop0 PUSH_PC pc_words=1 last=0; uop1 NORMAL last=1; one inst_done.
//  3. Call src with arg2=000001 -> PUSH_PC pc_words=2; then NORMAL.
//  4. Fill 2 + exec; inst_valid held -> inst_ready=0; on inst_done, next uop_valid same+1 cycle, no gap.
//  5. flush during PUSH_PC with 2 queued -> next cycle uop_valid=0, busy=0, no inst_done.
//  6. PUSHM_EN: 0x10CB (push, mask 1011) -> PUSH_REG r6, r2, r0, idx 0..2, last on r0; 0x10E0 -> no uops.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the micro-op sequencer.
//   - uop kind codes driven on uop_kind
//   - exec FSM states and per-instruction sequencing modes
//   - instruction match patterns (call, call-src, push/pop-multiple)
//   - popcount / highest-set / lowest-set helpers used to walk the
//     remaining-uop mask
// Optional feature macro: UOP_SEQUENCER_PUSHM_EN (push/pop-multiple patterns).
package seq_pkg;

  typedef enum logic [1:0] {
    UOP_NORMAL   = 2'd0,
    UOP_PUSH_PC  = 2'd1,
    UOP_PUSH_REG = 2'd2,
    UOP_POP_REG  = 2'd3
  } uop_kind_e;

  typedef enum logic {
    EXEC_IDLE,
    EXEC_RUN
  } exec_state_e;

  // How the remaining-uop mask of the current instruction is interpreted.
  typedef enum logic [1:0] {
    SEQ_SINGLE,
    SEQ_CALL,
    SEQ_PUSHM,
    SEQ_POPM
  } seq_mode_e;

  localparam logic [3:0]  CC_CALL       = 4'hF;

  // 0000/CC_CALL/bbbbbbbb
  localparam logic [15:0] CALL_BR_PAT   = {4'b0000, CC_CALL, 8'h00};
  localparam logic [15:0] CALL_BR_MASK  = 16'hFF00;
  // 0010000001iiiiii
  localparam logic [15:0] CALL_SRC_PAT  = 16'h2040;
  localparam logic [15:0] CALL_SRC_MASK = 16'hFFC0;

`ifdef UOP_SEQUENCER_PUSHM_EN
  // 0001_0000_11_d0_mmmm
  localparam logic [15:0] PUSHM_PAT     = 16'h10C0;
  localparam logic [15:0] PUSHM_MASK    = 16'hFFD0;
`endif

  function automatic logic [2:0] popcount4(input logic [3:0] m);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, m[i]};
    return n;
  endfunction

  function automatic logic [1:0] msb_idx4(input logic [3:0] m);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [1:0] lsb_idx4(input logic [3:0] m);
    logic [1:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) if (m[i]) r = 2'(i);
    return r;
  endfunction

endpackage

// File: rtl/uop_sequencer_inst_fifo.sv
// inst_fifo: synchronous instruction FIFO.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   clear       drop all entries (PC redirect)
//   push, din   write one word (legal while full if pop is also high)
//   pop, dout   head word is dout; pop advances it
//   full, empty occupancy flags
// DEPTH must be a power of two, >= 1.
module inst_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines validity. When full
  // with push+pop, the write lands on the slot being read out this cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/uop_sequencer.sv
// uop_sequencer: instruction front buffer plus micro-op sequencer.
// Queues fetched 16-bit instructions and issues each as 1..MAX_UOPS
// micro-ops, one at a time, to the scheduler.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   inst_valid/inst/inst_ready  fetch handshake (ready low during flush)
//   flush          PC redirect: drop queued and executing instruction
//   uop_valid, uop_inst, uop_kind, uop_reg, uop_pc_words, uop_index,
//   uop_last       current micro-op presented to the scheduler
//   uop_done       scheduler finished the current micro-op
//   inst_done      last micro-op of the instruction completes this cycle
//   busy           micro-op presented or instructions queued
// Optional feature macro: UOP_SEQUENCER_PUSHM_EN enables push/pop-multiple
// expansion into PUSH_REG / POP_REG micro-ops.
module uop_sequencer
  import seq_pkg::*;
#(
  parameter int LOG2_NR    = 4,
  parameter int NSHIFT     = 2,
  parameter int MAX_UOPS   = 5,
  parameter int IBUF_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        inst_valid,
  input  logic [15:0]                 inst,
  output logic                        inst_ready,
  input  logic                        flush,
  output logic                        uop_valid,
  output logic [15:0]                 uop_inst,
  output logic [1:0]                  uop_kind,
  output logic [LOG2_NR-1:0]          uop_reg,
  output logic [NSHIFT-1:0]           uop_pc_words,
  output logic [$clog2(MAX_UOPS)-1:0] uop_index,
  output logic                        uop_last,
  input  logic                        uop_done,
  output logic                        inst_done,
  output logic                        busy
);

  localparam int IW = $clog2(MAX_UOPS);

  exec_state_e       state_q, state_d;
  seq_mode_e         mode_q, mode_d, dec_mode;
  logic [3:0]        rem_q, rem_d, dec_rem;
  logic [IW-1:0]     idx_q, idx_d;
  logic [15:0]       inst_q, inst_d, load_word;
  logic [NSHIFT-1:0] pcw_q, pcw_d, dec_pcw;
  logic [1:0]        cur_k;
  logic              silent, retire, can_load, load_fifo, bypass;
  logic              fifo_push, fifo_full, fifo_empty;
  logic [15:0]       fifo_head;

  inst_fifo #(.DEPTH(IBUF_DEPTH), .W(16)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (fifo_push),
    .din   (inst),
    .pop   (load_fifo),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    uop_valid    = 1'b0;
    uop_kind     = UOP_NORMAL;
    uop_reg      = '0;
    uop_pc_words = '0;
    uop_last     = 1'b0;
    silent       = 1'b0;
    state_d      = state_q;
    mode_d       = mode_q;
    rem_d        = rem_q;
    idx_d        = idx_q;
    inst_d       = inst_q;
    pcw_d        = pcw_q;
    dec_mode     = SEQ_SINGLE;
    dec_rem      = '0;
    dec_pcw      = NSHIFT'(1);

    // Pushes walk the mask high->low, pops low->high.
    cur_k = (mode_q == SEQ_PUSHM) ? msb_idx4(rem_q) : lsb_idx4(rem_q);

    if (state_q == EXEC_RUN) begin
      unique case (mode_q)
        SEQ_CALL: begin
          uop_valid = 1'b1;
          if (rem_q[0]) begin
            uop_kind     = UOP_PUSH_PC;
            uop_pc_words = pcw_q;
          end else begin
            uop_last = 1'b1;
          end
        end
        SEQ_PUSHM, SEQ_POPM: begin
          // An empty register mask issues nothing and retires on its own.
          if (rem_q == '0) begin
            silent = 1'b1;
          end else begin
            uop_valid = 1'b1;
            uop_kind  = (mode_q == SEQ_PUSHM) ? UOP_PUSH_REG : UOP_POP_REG;
            uop_reg   = LOG2_NR'({cur_k, 1'b0});
            uop_last  = (popcount4(rem_q) == 3'd1);
          end
        end
        default: begin
          uop_valid = 1'b1;
          uop_last  = 1'b1;
        end
      endcase
    end

    inst_done  = uop_valid & uop_done & uop_last;
    retire     = inst_done | silent;
    can_load   = ((state_q == EXEC_IDLE) | retire) & ~flush;
    load_fifo  = can_load & ~fifo_empty;
    // Empty FIFO and a free exec slot: take the fetched word directly so a
    // fresh instruction is presented the very next cycle.
    bypass     = can_load & fifo_empty & inst_valid;
    inst_ready = ~flush & (~fifo_full | load_fifo);
    fifo_push  = inst_valid & inst_ready & ~bypass;
    load_word  = load_fifo ? fifo_head : inst;

    if ((load_word & CALL_BR_MASK) == CALL_BR_PAT) begin
      dec_mode = SEQ_CALL;
      dec_rem  = 4'b0001;
    end else if ((load_word & CALL_SRC_MASK) == CALL_SRC_PAT) begin
      dec_mode = SEQ_CALL;
      dec_rem  = 4'b0001;
      // Long-form source operand occupies an extra word after the call.
      if (load_word[5:2] == 4'b0000 && load_word[0]) dec_pcw = NSHIFT'(2);
`ifdef UOP_SEQUENCER_PUSHM_EN
    end else if ((load_word & PUSHM_MASK) == PUSHM_PAT) begin
      dec_mode = load_word[5] ? SEQ_POPM : SEQ_PUSHM;
      dec_rem  = load_word[3:0];
`endif
    end

    if (state_q == EXEC_RUN && flush) begin
      state_d = EXEC_IDLE;
    end else if (can_load && (load_fifo || bypass)) begin
      state_d = EXEC_RUN;
      inst_d  = load_word;
      mode_d  = dec_mode;
      rem_d   = dec_rem;
      idx_d   = '0;
      pcw_d   = dec_pcw;
    end else if (retire) begin
      state_d = EXEC_IDLE;
    end else if (uop_valid && uop_done) begin
      idx_d = idx_q + IW'(1);
      unique case (mode_q)
        SEQ_CALL:  rem_d = '0;
        SEQ_PUSHM,
        SEQ_POPM:  rem_d = rem_q & ~(4'b0001 << cur_k);
        default:   ;
      endcase
    end
  end

  // ---- exec register stage ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EXEC_IDLE;
      mode_q  <= SEQ_SINGLE;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    inst_q <= inst_d;
    pcw_q  <= pcw_d;
  end

  // Unreset data is masked while idle so outputs read zero out of reset.
  assign uop_inst  = (state_q == EXEC_RUN) ? inst_q : '0;
  assign uop_index = (state_q == EXEC_RUN) ? idx_q : '0;
  assign busy      = uop_valid | ~fifo_empty;

endmodule

// File: tb/tb_uop_sequencer.sv
module tb_uop_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic [15:0] inst;
  logic        inst_ready;
  logic        flush;
  logic        uop_valid;
  logic [15:0] uop_inst;
  logic [1:0]  uop_kind;
  logic [3:0]  uop_reg;
  logic [1:0]  uop_pc_words;
  logic [2:0]  uop_index;
  logic        uop_last;
  logic        uop_done;
  logic        inst_done;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] inst;
    logic [1:0]  kind;
    logic [3:0]  rgs;
    logic [1:0]  pc;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb[$];

  uop_sequencer #(.LOG2_NR(4), .NSHIFT(2), .MAX_UOPS(5), .IBUF_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_ready   (inst_ready),
    .flush        (flush),
    .uop_valid    (uop_valid),
    .uop_inst     (uop_inst),
    .uop_kind     (uop_kind),
    .uop_reg      (uop_reg),
    .uop_pc_words (uop_pc_words),
    .uop_index    (uop_index),
    .uop_last     (uop_last),
    .uop_done     (uop_done),
    .inst_done    (inst_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference expansion of one accepted instruction into expected uops.
  task automatic sb_push_model(input logic [15:0] w);
    exp_t e;
    logic [1:0] pc;
    int total;
    int n;
    if (w[15:12] == 4'h0 && w[11:8] == 4'hF) begin
      e = '{inst: w, kind: 2'd1, rgs: 4'd0, pc: 2'd1, idx: 3'd0, last: 1'b0}; sb.push_back(e);
      e = '{inst: w, kind: 2'd0, rgs: 4'd0, pc: 2'd0, idx: 3'd1, last: 1'b1}; sb.push_back(e);
    end else if (w[15:6] == 10'b0010000001) begin
      pc = (w[5:2] == 4'b0000 && w[0] == 1'b1) ? 2'd2 : 2'd1;
      e = '{inst: w, kind: 2'd1, rgs: 4'd0, pc: pc, idx: 3'd0, last: 1'b0}; sb.push_back(e);
      e = '{inst: w, kind: 2'd0, rgs: 4'd0, pc: 2'd0, idx: 3'd1, last: 1'b1}; sb.push_back(e);
`ifdef UOP_SEQUENCER_PUSHM_EN
    end else if (w[15:12] == 4'h1 && w[11:8] == 4'h0 && w[7:6] == 2'b11 && w[4] == 1'b0) begin
      total = 0;
      for (int k = 0; k < 4; k++) if (w[k]) total++;
      n = 0;
      for (int j = 0; j < 4; j++) begin
        int k;
        k = w[5] ? j : 3 - j;
        if (w[k]) begin
          e = '{inst: w, kind: (w[5] ? 2'd3 : 2'd2), rgs: 4'(2 * k), pc: 2'd0,
                idx: 3'(n), last: (n == total - 1)};
          sb.push_back(e);
          n++;
        end
      end
`endif
    end else begin
      e = '{inst: w, kind: 2'd0, rgs: 4'd0, pc: 2'd0, idx: 3'd0, last: 1'b1}; sb.push_back(e);
    end
  endtask

  // Scoreboard: expected uops pushed on acceptance, compared as presented.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
    end else begin
      if (uop_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected_uop: got inst=%h kind=%0d, want no uop", uop_inst, uop_kind);
        end else begin
          e = sb[0];
          if (uop_inst !== e.inst || uop_kind !== e.kind || uop_reg !== e.rgs ||
              uop_index !== e.idx || uop_last !== e.last ||
              (e.kind == 2'd1 && uop_pc_words !== e.pc)) begin
            miscompares++;
            $display("FAIL sb_uop: got inst=%h kind=%0d reg=%0d idx=%0d last=%0b pc=%0d, want inst=%h kind=%0d reg=%0d idx=%0d last=%0b pc=%0d",
                     uop_inst, uop_kind, uop_reg, uop_index, uop_last, uop_pc_words,
                     e.inst, e.kind, e.rgs, e.idx, e.last, e.pc);
          end
          if (uop_done) begin
            vectors++;
            if (inst_done !== e.last) begin
              miscompares++;
              $display("FAIL sb_inst_done: got %0b want %0b", inst_done, e.last);
            end
            void'(sb.pop_front());
          end
        end
      end
      if (flush) sb.delete();
      if (inst_valid && inst_ready) sb_push_model(inst);
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    vectors++; if (uop_valid !== 1'b0) begin miscompares++; $display("FAIL rst_uop_valid: got %0b want 0", uop_valid); end
    vectors++; if (uop_inst !== 16'h0) begin miscompares++; $display("FAIL rst_uop_inst: got %h want 0000", uop_inst); end
    vectors++; if (uop_kind !== 2'd0) begin miscompares++; $display("FAIL rst_uop_kind: got %0d want 0", uop_kind); end
    vectors++; if (uop_reg !== 4'd0) begin miscompares++; $display("FAIL rst_uop_reg: got %0d want 0", uop_reg); end
    vectors++; if (uop_index !== 3'd0) begin miscompares++; $display("FAIL rst_uop_index: got %0d want 0", uop_index); end
    vectors++; if (uop_last !== 1'b0) begin miscompares++; $display("FAIL rst_uop_last: got %0b want 0", uop_last); end
    vectors++; if (uop_pc_words !== 2'd0) begin miscompares++; $display("FAIL rst_pc_words: got %0d want 0", uop_pc_words); end
    vectors++; if (inst_done !== 1'b0) begin miscompares++; $display("FAIL rst_inst_done: got %0b want 0", inst_done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %0b want 0", busy); end
    vectors++; if (inst_ready !== 1'b1) begin miscompares++; $display("FAIL rst_inst_ready: got %0b want 1", inst_ready); end
    tick();
  endtask

  task automatic test_single();
    inst = 16'h8123;
    inst_valid = 1'b1;
    #1;
    vectors++; if (inst_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %0b want 1", inst_ready); end
    tick();
    inst_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      uop_done = (c == 3);
      #1;
      vectors++; if (uop_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid_c%0d: got %0b want 1", c, uop_valid); end
      vectors++; if (inst_done !== (c == 3)) begin miscompares++; $display("FAIL single_done_c%0d: got %0b want %0b", c, inst_done, (c == 3)); end
      tick();
    end
    uop_done = 1'b0;
    #1;
    vectors++; if (uop_valid !== 1'b0) begin miscompares++; $display("FAIL single_after_valid: got %0b want 0", uop_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_after_busy: got %0b want 0", busy); end
  endtask

  task automatic test_call();
    int ndone;
    ndone = 0;
    inst = 16'h0F5A;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    uop_done = 1'b1;
    #1;
    vectors++; if (uop_kind !== 2'd1) begin miscompares++; $display("FAIL call_kind0: got %0d want 1", uop_kind); end
    vectors++; if (uop_pc_words !== 2'd1) begin miscompares++; $display("FAIL call_pc: got %0d want 1", uop_pc_words); end
    vectors++; if (uop_last !== 1'b0) begin miscompares++; $display("FAIL call_last0: got %0b want 0", uop_last); end
    if (inst_done) ndone++;
    tick();
    vectors++; if (uop_kind !== 2'd0) begin miscompares++; $display("FAIL call_kind1: got %0d want 0", uop_kind); end
    vectors++; if (uop_index !== 3'd1) begin miscompares++; $display("FAIL call_idx1: got %0d want 1", uop_index); end
    if (inst_done) ndone++;
    tick();
    if (inst_done) ndone++;
    uop_done = 1'b0;
    vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL call_ndone: got %0d want 1", ndone); end
  endtask

  task automatic test_call_src();
    logic [15:0] words [2];
    logic [1:0]  pcs [2];
    words = '{16'h2041, 16'h2045};
    pcs   = '{2'd2, 2'd1};
    for (int i = 0; i < 2; i++) begin
      inst = words[i];
      inst_valid = 1'b1;
      tick();
      inst_valid = 1'b0;
      uop_done = 1'b1;
      #1;
      vectors++; if (uop_kind !== 2'd1) begin miscompares++; $display("FAIL csrc_kind0_%0d: got %0d want 1", i, uop_kind); end
      vectors++; if (uop_pc_words !== pcs[i]) begin miscompares++; $display("FAIL csrc_pc_%0d: got %0d want %0d", i, uop_pc_words, pcs[i]); end
      tick();
      vectors++; if (uop_kind !== 2'd0 || uop_last !== 1'b1) begin miscompares++; $display("FAIL csrc_body_%0d: got kind=%0d last=%0b want kind=0 last=1", i, uop_kind, uop_last); end
      tick();
      uop_done = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    uop_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inst = 16'h8001 + 16'(i);
      inst_valid = 1'b1;
      #1;
      vectors++; if (inst_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_%0d: got %0b want 1", i, inst_ready); end
      tick();
    end
    inst = 16'h8004;
    #1;
    vectors++; if (inst_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_full_ready: got %0b want 0", inst_ready); end
    tick();
    vectors++; if (inst_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_full_ready2: got %0b want 0", inst_ready); end
    vectors++; if (uop_inst !== 16'h8001) begin miscompares++; $display("FAIL b2b_head: got %h want 8001", uop_inst); end
    uop_done = 1'b1;
    #1;
    vectors++; if (inst_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_full_done_ready: got %0b want 1", inst_ready); end
    vectors++; if (inst_done !== 1'b1) begin miscompares++; $display("FAIL b2b_done: got %0b want 1", inst_done); end
    tick();
    inst_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #1;
      vectors++; if (uop_valid !== 1'b1 || uop_inst !== 16'h8001 + 16'(i)) begin miscompares++; $display("FAIL b2b_seq_%0d: got valid=%0b inst=%h want valid=1 inst=%h", i, uop_valid, uop_inst, 16'h8001 + 16'(i)); end
      tick();
    end
    uop_done = 1'b0;
    #1;
    vectors++; if (uop_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drained: got %0b want 0", uop_valid); end
  endtask

  task automatic test_flush();
    inst = 16'h0F34; inst_valid = 1'b1; tick();
    inst = 16'h8010; tick();
    inst = 16'h8011; tick();
    inst = 16'h8012;
    flush = 1'b1;
    #1;
    vectors++; if (inst_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready: got %0b want 0", inst_ready); end
    vectors++; if (uop_kind !== 2'd1) begin miscompares++; $display("FAIL flush_in_pushpc: got %0d want 1", uop_kind); end
    tick();
    flush = 1'b0;
    inst_valid = 1'b0;
    #1;
    vectors++; if (uop_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %0b want 0", uop_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy: got %0b want 0", busy); end
    uop_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (uop_valid !== 1'b0 || inst_done !== 1'b0) begin miscompares++; $display("FAIL flush_quiet_%0d: got valid=%0b done=%0b want 0 0", c, uop_valid, inst_done); end
      tick();
    end
    uop_done = 1'b0;
  endtask

  task automatic test_flush_done();
    inst = 16'h8020; inst_valid = 1'b1; tick();
    inst = 16'h8021; tick();
    inst_valid = 1'b0;
    uop_done = 1'b1;
    flush = 1'b1;
    #1;
    vectors++; if (inst_done !== 1'b1) begin miscompares++; $display("FAIL fdone_done: got %0b want 1", inst_done); end
    tick();
    flush = 1'b0;
    uop_done = 1'b0;
    #1;
    vectors++; if (uop_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL fdone_after: got valid=%0b busy=%0b want 0 0", uop_valid, busy); end
    tick();
  endtask

  task automatic test_reset_mid();
    inst = 16'h0F77; inst_valid = 1'b1; tick();
    inst = 16'h8040; tick();
    inst_valid = 1'b0;
    #1;
    vectors++; if (uop_kind !== 2'd1) begin miscompares++; $display("FAIL rmid_pushpc: got %0d want 1", uop_kind); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    uop_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (uop_valid !== 1'b0 || inst_done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rmid_quiet_%0d: got valid=%0b done=%0b busy=%0b want 0 0 0", c, uop_valid, inst_done, busy); end
      tick();
    end
    uop_done = 1'b0;
  endtask

  task automatic test_pushm();
`ifdef UOP_SEQUENCER_PUSHM_EN
    logic [3:0] regs [3];
    int ndone;
    regs = '{4'd6, 4'd2, 4'd0};
    ndone = 0;
    inst = 16'h10CB; inst_valid = 1'b1; tick();
    inst_valid = 1'b0;
    uop_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (uop_kind !== 2'd2 || uop_reg !== regs[i] || uop_index !== 3'(i) || uop_last !== (i == 2)) begin miscompares++; $display("FAIL pushm_%0d: got kind=%0d reg=%0d idx=%0d last=%0b want 2 %0d %0d %0b", i, uop_kind, uop_reg, uop_index, uop_last, regs[i], i, (i == 2)); end
      if (inst_done) ndone++;
      tick();
    end
    vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL pushm_ndone: got %0d want 1", ndone); end
    inst = 16'h10E0; inst_valid = 1'b1; tick();
    inst_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (uop_valid !== 1'b0 || inst_done !== 1'b0) begin miscompares++; $display("FAIL pushm_empty_%0d: got valid=%0b done=%0b want 0 0", c, uop_valid, inst_done); end
      tick();
    end
    inst = 16'h10E5; inst_valid = 1'b1; tick();
    inst_valid = 1'b0;
    #1;
    vectors++; if (uop_kind !== 2'd3 || uop_reg !== 4'd0) begin miscompares++; $display("FAIL popm_0: got kind=%0d reg=%0d want 3 0", uop_kind, uop_reg); end
    tick();
    vectors++; if (uop_kind !== 2'd3 || uop_reg !== 4'd4 || uop_last !== 1'b1) begin miscompares++; $display("FAIL popm_1: got kind=%0d reg=%0d last=%0b want 3 4 1", uop_kind, uop_reg, uop_last); end
    tick();
    uop_done = 1'b0;
`else
    inst = 16'h10CB; inst_valid = 1'b1; tick();
    inst_valid = 1'b0;
    uop_done = 1'b1;
    #1;
    vectors++; if (uop_kind !== 2'd0 || uop_last !== 1'b1 || inst_done !== 1'b1) begin miscompares++; $display("FAIL pushm_off: got kind=%0d last=%0b done=%0b want 0 1 1", uop_kind, uop_last, inst_done); end
    tick();
    uop_done = 1'b0;
`endif
    #1;
    vectors++; if (uop_valid !== 1'b0) begin miscompares++; $display("FAIL pushm_drained: got %0b want 0", uop_valid); end
  endtask

  initial begin
    reset = 1'b1;
    inst_valid = 1'b0;
    inst = 16'h0;
    flush = 1'b0;
    uop_done = 1'b0;
    test_reset();
    test_single();
    test_call();
    test_call_src();
    test_back_to_back();
    test_flush();
    test_flush_done();
    test_reset_mid();
    test_pushm();
    tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d pending uops want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
